l2_cache: RTL and testbench
===========================

L2_CACHE -- requirements
Module: l2_cache

Interface
REQ-001 SHALL have one parameter: INDEX_BITS, default 4, log2 of line count (16 direct-mapped lines of 4 x 32-bit words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port proc_reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port L2_read, input, 1, L1 read request, held until L2_ready.
REQ-005 SHALL have port L2_write, input, 1, L1 write-through request, held until L2_ready.
REQ-006 SHALL have port L2_addr, input, 30, word address: offset [1:0], index [INDEX_BITS+1:2], tag [29:INDEX_BITS+2].
REQ-007 SHALL have port L2_wdata, input, 32, write word.
REQ-008 SHALL have port L2_rdata, output, 128, full line; word w at bits [32w+31:32w].
REQ-009 SHALL have port L2_ready, output, 1, one-cycle completion pulse.
REQ-010 SHALL have ports mem_read and mem_write, output, 1 each, memory requests.
REQ-011 SHALL have port mem_addr, output, 28, block address {tag,index}.
REQ-012 SHALL have ports mem_wdata, output, 128, and mem_rdata, input, 128, line data.
REQ-013 SHALL have port mem_ready, input, 1, memory completion; only meaningful while mem_read or mem_write is high.

Function
REQ-014 SHALL be direct-mapped, write-back, write-allocate; each line holds valid, dirty, tag, 128-bit data.
REQ-015 SHALL implement states IDLE, WRITEBACK, ALLOCATE, RESP.
REQ-016 In IDLE, when L2_read or L2_write is high, SHALL latch address, wdata and op into request registers; all later decisions use latched values.
REQ-017 If L2_read and L2_write are both high, SHALL treat the request as a write.
REQ-018 Hit (valid and tag match) in IDLE: SHALL merge write word (write op, set dirty), load L2_rdata with the resulting line, go to RESP; L2_ready high in the next cycle.
REQ-019 Miss with clean or invalid victim: IDLE -> ALLOCATE.
REQ-020 Miss with valid dirty victim: IDLE -> WRITEBACK.
REQ-021 In WRITEBACK: mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim line; on mem_ready -> ALLOCATE, mem_write low the following cycle.
REQ-022 In ALLOCATE: mem_read=1, mem_addr={request tag,index}; on mem_ready SHALL write line = mem_rdata (write op: latched word merged in, dirty=1; read: dirty=0), set valid and tag, load L2_rdata with the stored line, go to RESP.
REQ-023 mem_read and mem_write SHALL never be high simultaneously and SHALL be low in IDLE and RESP.
REQ-024 RESP SHALL last exactly one cycle with L2_ready=1, ignore requests, and return to IDLE.
REQ-025 L2_rdata SHALL hold its value outside RESP until the next load.
REQ-026 A request still held in the IDLE cycle after RESP SHALL be serviced again (idempotent re-hit, no deduplication).
REQ-027 Latency: hit 1 cycle request-to-ready; clean miss = memory latency + 2; dirty miss = both memory latencies + 3.

Reset
REQ-028 On proc_reset: state=IDLE, all valid/dirty/tag/data cleared, L2_ready=0, L2_rdata=0, mem_read=mem_write=0 in the next cycle.
REQ-029 Reset mid-WRITEBACK/ALLOCATE SHALL abort the transaction with no line update; late mem_ready/mem_rdata is ignored.

Verification
REQ-030 Cold read addr 0x0000_0010, memory returns 0x4444_3333_2222_1111_... -> mem_read with mem_addr=0x0000004, L2_ready pulse, L2_rdata = returned line.
REQ-031 Repeat read same address -> L2_ready 1 cycle after request, no memory access.
REQ-032 Write 0xDEADBEEF to 0x0000_0012 (hit) -> L2_rdata[95:64]=0xDEADBEEF, line dirty, no mem_write.
REQ-033 Read 0x0000_0052 (same index 4, new tag) -> mem_write of dirty line at mem_addr 0x0000004 precedes mem_read at 0x0000014.
REQ-034 L2_read and L2_write both high -> write performed; assert proc_reset during ALLOCATE -> next cycle mem_read=0, state IDLE, subsequent read misses.

Source files
------------

// File: rtl/l2_cache.sv
// l2_cache: direct-mapped write-back write-allocate L2 with 128-bit lines behind a word-addressed L1 port
module l2_cache #(
    parameter int INDEX_BITS = 4
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         L2_read,
    input  logic         L2_write,
    input  logic [29:0]  L2_addr,
    input  logic [31:0]  L2_wdata,
    output logic [127:0] L2_rdata,
    output logic         L2_ready,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, RESP} state_t;

    state_t                state_q, state_d;
    logic [29:0]           req_addr_q, req_addr_d;
    logic [31:0]           req_wdata_q, req_wdata_d;
    logic                  req_write_q, req_write_d;
    logic [127:0]          rdata_q, rdata_d;

    logic                  valid_q [LINES];
    logic                  dirty_q [LINES];
    logic [TAG_BITS-1:0]   tag_q   [LINES];
    logic [127:0]          data_q  [LINES];

    logic                  we;
    logic [INDEX_BITS-1:0] widx;
    logic [TAG_BITS-1:0]   wtag;
    logic                  wdirty;
    logic [127:0]          wline;

    logic [INDEX_BITS-1:0] idx_in, idx_r;
    logic [TAG_BITS-1:0]   tag_in, tag_r;
    logic [1:0]            off_in, off_r;

    assign idx_in = L2_addr[INDEX_BITS+1:2];
    assign tag_in = L2_addr[29:INDEX_BITS+2];
    assign off_in = L2_addr[1:0];
    assign idx_r  = req_addr_q[INDEX_BITS+1:2];
    assign tag_r  = req_addr_q[29:INDEX_BITS+2];
    assign off_r  = req_addr_q[1:0];

    assign L2_rdata = rdata_q;
    assign L2_ready = (state_q == RESP);

    // Next state, line-update port and memory request outputs; hits resolve on live inputs in IDLE
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_write_d = req_write_q;
        rdata_d     = rdata_q;
        we          = 1'b0;
        widx        = idx_r;
        wtag        = tag_r;
        wdirty      = 1'b0;
        wline       = mem_rdata;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = {tag_r, idx_r};
        mem_wdata   = data_q[idx_r];
        case (state_q)
            IDLE: begin
                if (L2_read || L2_write) begin
                    req_addr_d  = L2_addr;
                    req_wdata_d = L2_wdata;
                    req_write_d = L2_write;
                    if (valid_q[idx_in] && tag_q[idx_in] == tag_in) begin
                        wline = data_q[idx_in];
                        if (L2_write) wline[{off_in, 5'd0} +: 32] = L2_wdata;
                        we      = L2_write;
                        widx    = idx_in;
                        wtag    = tag_in;
                        wdirty  = 1'b1;
                        rdata_d = wline;
                        state_d = RESP;
                    end else begin
                        state_d = (valid_q[idx_in] && dirty_q[idx_in]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                mem_write = 1'b1;
                mem_addr  = {tag_q[idx_r], idx_r};
                if (mem_ready) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    if (req_write_q) wline[{off_r, 5'd0} +: 32] = req_wdata_q;
                    we      = 1'b1;
                    wdirty  = req_write_q;
                    rdata_d = wline;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and request registers; reset abandons any memory transaction in flight
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_write_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_write_q <= req_write_d;
            rdata_q     <= rdata_d;
        end
    end

    // Line storage with a single write port; reset invalidates and clears every line
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else if (we) begin
            valid_q[widx] <= 1'b1;
            dirty_q[widx] <= wdirty;
            tag_q[widx]   <= wtag;
            data_q[widx]  <= wline;
        end
    end
endmodule

// File: tb/tb_l2_cache.sv
// tb_l2_cache: directed checks of hit, clean/dirty miss, combined op and reset abort
module tb_l2_cache;
    logic         clk = 1'b0;
    logic         proc_reset;
    logic         L2_read, L2_write;
    logic [29:0]  L2_addr;
    logic [31:0]  L2_wdata;
    logic [127:0] L2_rdata;
    logic         L2_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;

    int total = 0;
    int bad = 0;

    localparam logic [127:0] LINE1  = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] LINE1W = 128'h4444_4444_DEAD_BEEF_2222_2222_1111_1111;
    localparam logic [127:0] LINE1C = 128'h4444_4444_DEAD_BEEF_CAFE_F00D_1111_1111;
    localparam logic [127:0] LINE2  = 128'h8888_8888_7777_7777_6666_6666_5555_5555;

    l2_cache dut (
        .clk(clk), .proc_reset(proc_reset),
        .L2_read(L2_read), .L2_write(L2_write), .L2_addr(L2_addr), .L2_wdata(L2_wdata),
        .L2_rdata(L2_rdata), .L2_ready(L2_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
        L2_read = rd; L2_write = wr; L2_addr = a; L2_wdata = d;
    endtask

    initial begin
        proc_reset = 1'b1;
        req(1'b0, 1'b0, 30'h0, 32'h0);
        mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", L2_ready, 0);
        check("rst_rdata", L2_rdata, 0);
        check("rst_mem_rd", mem_read, 0);
        check("rst_mem_wr", mem_write, 0);
        proc_reset = 1'b0;

        // cold read miss on a clean invalid line
        req(1'b1, 1'b0, 30'h10, 32'h0);
        @(negedge clk);
        check("cold_mem_rd", mem_read, 1);
        check("cold_mem_wr", mem_write, 0);
        check("cold_addr", mem_addr, 28'h4);
        check("cold_not_ready", L2_ready, 0);
        mem_rdata = LINE1; mem_ready = 1'b1;
        @(negedge clk);
        check("cold_ready", L2_ready, 1);
        check("cold_rdata", L2_rdata, LINE1);
        check("cold_resp_mem_rd", mem_read, 0);
        mem_ready = 1'b0; req(1'b0, 1'b0, 30'h0, 32'h0);

        // read hit, held one extra round to get a second service
        @(negedge clk);
        req(1'b1, 1'b0, 30'h10, 32'h0);
        @(negedge clk);
        check("hit_ready", L2_ready, 1);
        check("hit_mem_rd", mem_read, 0);
        check("hit_rdata", L2_rdata, LINE1);
        @(negedge clk);
        check("hit_idle_gap", L2_ready, 0);
        @(negedge clk);
        check("rehit_ready", L2_ready, 1);
        req(1'b0, 1'b0, 30'h0, 32'h0);
        @(negedge clk);
        check("hold_ready_low", L2_ready, 0);
        check("hold_rdata", L2_rdata, LINE1);

        // write hit into word 2
        req(1'b0, 1'b1, 30'h12, 32'hDEADBEEF);
        @(negedge clk);
        check("whit_ready", L2_ready, 1);
        check("whit_mem_wr", mem_write, 0);
        check("whit_rdata", L2_rdata, LINE1W);
        req(1'b0, 1'b0, 30'h0, 32'h0);
        @(negedge clk);

        // conflict read evicts the dirty line first
        req(1'b1, 1'b0, 30'h52, 32'h0);
        @(negedge clk);
        check("wb_mem_wr", mem_write, 1);
        check("wb_mem_rd", mem_read, 0);
        check("wb_addr", mem_addr, 28'h4);
        check("wb_wdata", mem_wdata, LINE1W);
        @(negedge clk);
        check("wb_hold", mem_write, 1);
        mem_ready = 1'b1;
        @(negedge clk);
        check("al_mem_wr", mem_write, 0);
        check("al_mem_rd", mem_read, 1);
        check("al_addr", mem_addr, 28'h14);
        mem_rdata = LINE2;
        @(negedge clk);
        check("al_ready", L2_ready, 1);
        check("al_rdata", L2_rdata, LINE2);
        mem_ready = 1'b0; req(1'b0, 1'b0, 30'h0, 32'h0);
        @(negedge clk);

        // old tag returns: victim is clean so no writeback
        req(1'b1, 1'b0, 30'h10, 32'h0);
        @(negedge clk);
        check("clean_mem_wr", mem_write, 0);
        check("clean_mem_rd", mem_read, 1);
        check("clean_addr", mem_addr, 28'h4);
        mem_rdata = LINE1W; mem_ready = 1'b1;
        @(negedge clk);
        check("clean_rdata", L2_rdata, LINE1W);
        mem_ready = 1'b0; req(1'b0, 1'b0, 30'h0, 32'h0);
        @(negedge clk);

        // read and write together behave as a write
        req(1'b1, 1'b1, 30'h11, 32'hCAFEF00D);
        @(negedge clk);
        check("both_ready", L2_ready, 1);
        check("both_rdata", L2_rdata, LINE1C);
        req(1'b0, 1'b0, 30'h0, 32'h0);
        @(negedge clk);
        req(1'b1, 1'b0, 30'h50, 32'h0);
        @(negedge clk);
        check("both_dirty_wb", mem_write, 1);
        check("both_wdata", mem_wdata, LINE1C);
        mem_ready = 1'b1;
        @(negedge clk);
        check("abort_pre_rd", mem_read, 1);
        mem_ready = 1'b0;

        // reset during allocate abandons the fill
        proc_reset = 1'b1; req(1'b0, 1'b0, 30'h0, 32'h0);
        @(negedge clk);
        check("abort_mem_rd", mem_read, 0);
        check("abort_ready", L2_ready, 0);
        check("abort_rdata", L2_rdata, 0);
        proc_reset = 1'b0; mem_rdata = LINE1; mem_ready = 1'b1;
        @(negedge clk);
        check("late_ready_ignored", L2_ready, 0);
        mem_ready = 1'b0;
        req(1'b1, 1'b0, 30'h50, 32'h0);
        @(negedge clk);
        check("post_rst_mem_wr", mem_write, 0);
        check("post_rst_mem_rd", mem_read, 1);
        check("post_rst_addr", mem_addr, 28'h14);
        mem_rdata = LINE2; mem_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", L2_ready, 1);
        check("post_rst_rdata", L2_rdata, LINE2);
        mem_ready = 1'b0; req(1'b0, 1'b0, 30'h0, 32'h0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
